uart_rx_packet: RTL
===================

// Module: uart_rx_packet
// PURPOSE
//  Frame parser directly downstream of the UART receiver, on the same baud clock.
//  Takes received bytes (data/done/error) and assembles frames: SOF, CMD, LEN, LEN payload bytes, CSUM.
//  CSUM = XOR of CMD, LEN and all payload bytes. Buffers the payload and checks length, checksum and inter-byte timeout.
//  Presents each good frame to the command layer with a valid/ready handshake.
// PARAMETERS
//  SOF_BYTE        8'hA5  start-of-frame marker
//  MAX_PAYLOAD     16     payload buffer depth in bytes (LEN limit)
//  TIMEOUT_CYCLES  4096   max baud cycles between bytes inside a frame
// PORTS
//  baud         in   1               clock (oversampled baud clk, same as receiver)
//  reset        in   1               synchronous, active-high reset
//  rx_data      in   8               receiver data byte, valid when rx_done=1
//  rx_done      in   1               one-cycle pulse: rx_data holds a new byte
//  rx_error     in   1               receiver parity/stop error pulse
//  pkt_valid    out  1               good frame available
//  pkt_ready    in   1               consumer accepts frame
//  pkt_cmd      out  8               frame CMD byte, stable while pkt_valid
//  pkt_len      out  $clog2(MAX_PAYLOAD+1)  frame LEN, stable while pkt_valid
//  rd_addr      in   $clog2(MAX_PAYLOAD)    payload read index
//  rd_data      out  8               payload[rd_addr], registered, 1-cycle latency
//  busy         out  1               1 in any state except S_SOF
//  err_checksum out  1               one-cycle pulse: CSUM mismatch
//  err_length   out  1               one-cycle pulse: LEN > MAX_PAYLOAD
//  err_timeout  out  1               one-cycle pulse: inter-byte timeout
//  err_rx       out  1               one-cycle pulse: rx_error aborted a frame
//  err_overrun  out  1               one-cycle pulse: byte dropped while frame held
// BEHAVIOUR
//  - Reset: state=S_SOF. All outputs 0, including pkt_cmd, pkt_len and rd_data. Checksum accumulator, byte counter and timeout counter are 0.
//    Reset mid-frame discards the partial frame. No error pulse.
//  - A byte is accepted on a posedge baud with rx_done=1. All transitions are registered.
//  - States:
//    - S_SOF: byte==SOF_BYTE -> S_CMD. Any other byte is silently discarded.
//    - S_CMD: store cmd, csum<=byte -> S_LEN.
//    - S_LEN: LEN>MAX_PAYLOAD -> err_length, S_SOF.
//      LEN==0 -> S_CSUM.
//      Else store LEN, cnt<=0 -> S_PAYLOAD. csum^=byte in all non-error cases.
//    - S_PAYLOAD: buf[cnt]<=byte, csum^=byte, cnt++. After the byte with cnt==LEN-1 -> S_CSUM.
//    - S_CSUM: byte==csum -> pkt_valid<=1 (next cycle), S_HOLD. Else err_checksum, S_SOF.
//    - S_HOLD: when pkt_valid&&pkt_ready, pkt_valid<=0, -> S_SOF.
//  - S_HOLD bytes: rx_done -> byte dropped, err_overrun pulse. This includes the cycle where pkt_ready is high.
//    Buffer, pkt_cmd and pkt_len are not modified while pkt_valid=1.
//  - Timeout: counter clears on every accepted byte and on entry to S_CMD.
//    In S_CMD..S_CSUM it increments each cycle without rx_done.
//    At TIMEOUT_CYCLES-1 -> err_timeout, S_SOF. An rx_done in the same cycle wins: the byte is accepted and there is no timeout.
//    The counter does not run in S_SOF or S_HOLD.
//  - rx_error in S_CMD..S_CSUM -> err_rx, S_SOF, byte ignored. rx_error wins over a simultaneous rx_done.
//    rx_error in S_SOF or S_HOLD is ignored.
//  - Error pulses are high for exactly one cycle. At most one error pulse asserts per cycle.
//  - rd_data <= buf[rd_addr] every cycle. Out-of-range rd_addr (>=MAX_PAYLOAD) returns 0.
//  - Latency: pkt_valid rises 1 cycle after the CSUM byte's rx_done.
// TESTING
//  1. Good frame A5,01,03,11,22,33,csum=01^03^11^22^33=0x02.
//     -> pkt_valid=1 one cycle after the last done; pkt_cmd=01, pkt_len=3; rd_addr 0..2 reads 11,22,33.
//     pkt_ready=1 -> valid drops next cycle.
//  2. Zero-length frame A5,07,00,07.
//     -> pkt_valid, pkt_len=0. Bad csum A5,07,00,08 -> err_checksum pulse, no valid.
//  3. Noise 00,FF then A5,... -> noise ignored (no error), frame accepted.
//     LEN=MAX_PAYLOAD+1 -> err_length, back to S_SOF.
//  4. Frame stalls after LEN for TIMEOUT_CYCLES cycles -> err_timeout, busy=0.
//     rx_error during payload -> err_rx; the next good frame is parsed correctly.
//  5. While pkt_valid=1 and pkt_ready=0, send bytes -> err_overrun per byte; pkt_cmd and buffer unchanged.
//     rx_done together with pkt_ready -> still overrun.
//  6. Assert reset mid-payload -> all outputs 0 next cycle. A subsequent full frame is parsed correctly.

Source files
------------

// File: rtl/uart_rx_packet.sv
// uart_rx_packet: frame parser that sits directly behind the UART receiver.
// It assembles SOF, CMD, LEN, payload and CSUM into a frame and buffers the payload.
// Each good frame is presented to the command layer through a valid/ready handshake.
// Length, checksum, inter-byte timeout, receiver errors and overruns raise one-cycle pulses.
module uart_rx_packet #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         MAX_PAYLOAD    = 16,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                               baud,
    input  logic                               reset,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_done,
    input  logic                               rx_error,
    output logic                               pkt_valid,
    input  logic                               pkt_ready,
    output logic [7:0]                         pkt_cmd,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   pkt_len,
    input  logic [$clog2(MAX_PAYLOAD)-1:0]     rd_addr,
    output logic [7:0]                         rd_data,
    output logic                               busy,
    output logic                               err_checksum,
    output logic                               err_length,
    output logic                               err_timeout,
    output logic                               err_rx,
    output logic                               err_overrun
);

    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_PAYLOAD);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_SOF     = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] cnt_inc;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    pay_q [MAX_PAYLOAD];
    logic [7:0]    pay_d [MAX_PAYLOAD];
    logic          valid_q, valid_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          err_checksum_q, err_checksum_d;
    logic          err_length_q, err_length_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_rx_q, err_rx_d;
    logic          err_overrun_q, err_overrun_d;
    logic          in_frame;

    // Next-state logic: frame parsing, checksum accumulation, timeout and error pulses
    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        csum_d         = csum_q;
        tmo_d          = tmo_q;
        pay_d          = pay_q;
        valid_d        = valid_q;
        err_checksum_d = 1'b0;
        err_length_d   = 1'b0;
        err_timeout_d  = 1'b0;
        err_rx_d       = 1'b0;
        err_overrun_d  = 1'b0;
        cnt_inc        = cnt_q + LW'(1);
        in_frame       = (state_q == S_CMD) || (state_q == S_LEN) ||
                         (state_q == S_PAYLOAD) || (state_q == S_CSUM);

        if (in_frame) begin
            // A receiver error aborts the frame even when a byte arrives with it
            if (rx_error) begin
                err_rx_d = 1'b1;
                state_d  = S_SOF;
                tmo_d    = '0;
            end else if (rx_done) begin
                tmo_d = '0;
                case (state_q)
                    S_CMD: begin
                        cmd_d   = rx_data;
                        csum_d  = rx_data;
                        state_d = S_LEN;
                    end
                    S_LEN: begin
                        if (rx_data > MAX_LEN_B) begin
                            err_length_d = 1'b1;
                            state_d      = S_SOF;
                        end else begin
                            len_d   = rx_data[LW-1:0];
                            csum_d  = csum_q ^ rx_data;
                            cnt_d   = '0;
                            state_d = (rx_data == 8'h00) ? S_CSUM : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        pay_d[cnt_q[AW-1:0]] = rx_data;
                        csum_d               = csum_q ^ rx_data;
                        cnt_d                = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                    default: begin
                        if (rx_data == csum_q) begin
                            valid_d = 1'b1;
                            state_d = S_HOLD;
                        end else begin
                            err_checksum_d = 1'b1;
                            state_d        = S_SOF;
                        end
                    end
                endcase
            end else if (tmo_q == TMO_LAST) begin
                err_timeout_d = 1'b1;
                state_d       = S_SOF;
                tmo_d         = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else if (state_q == S_HOLD) begin
            // The held frame is never disturbed; any byte arriving now is lost
            tmo_d = '0;
            if (rx_done) begin
                err_overrun_d = 1'b1;
            end
            if (valid_q && pkt_ready) begin
                valid_d = 1'b0;
                state_d = S_SOF;
            end
        end else begin
            // Hunting for the start marker; anything else is line noise
            tmo_d   = '0;
            state_d = (rx_done && (rx_data == SOF_BYTE)) ? S_CMD : S_SOF;
        end
    end

    // Payload read port: registered, zero for addresses beyond the buffer
    always_comb begin
        rd_data_d = 8'h00;
        if ({{(32-AW){1'b0}}, rd_addr} < 32'(MAX_PAYLOAD)) begin
            rd_data_d = pay_q[rd_addr];
        end
    end

    // State registers with synchronous reset that drops any partial frame
    always_ff @(posedge baud) begin
        if (reset) begin
            state_q        <= S_SOF;
            cmd_q          <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            csum_q         <= '0;
            tmo_q          <= '0;
            valid_q        <= 1'b0;
            rd_data_q      <= '0;
            err_checksum_q <= 1'b0;
            err_length_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_rx_q       <= 1'b0;
            err_overrun_q  <= 1'b0;
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                pay_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            csum_q         <= csum_d;
            tmo_q          <= tmo_d;
            valid_q        <= valid_d;
            rd_data_q      <= rd_data_d;
            err_checksum_q <= err_checksum_d;
            err_length_q   <= err_length_d;
            err_timeout_q  <= err_timeout_d;
            err_rx_q       <= err_rx_d;
            err_overrun_q  <= err_overrun_d;
            pay_q          <= pay_d;
        end
    end

    assign pkt_valid    = valid_q;
    assign pkt_cmd      = cmd_q;
    assign pkt_len      = len_q;
    assign rd_data      = rd_data_q;
    assign busy         = (state_q != S_SOF);
    assign err_checksum = err_checksum_q;
    assign err_length   = err_length_q;
    assign err_timeout  = err_timeout_q;
    assign err_rx       = err_rx_q;
    assign err_overrun  = err_overrun_q;

endmodule
